// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first, valid/ready load.
// Optional even-parity trailer bit enabled by `define PISO_TX_PARITY_EN.
module piso_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             inv,
   input  logic             pause,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PISO_TX_PARITY_EN
      , PAR = 2'd2
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] load_word;
   logic             last_bit;
   logic             frame_end;
   logic             accept;
`ifdef PISO_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   always_comb begin
      last_bit  = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`ifdef PISO_TX_PARITY_EN
      frame_end = (state_q == PAR) && !pause;
`else
      frame_end = last_bit && !pause;
`endif
      // The final-bit cycle doubles as the load window so frames can abut.
      load_ready = (state_q == IDLE) || frame_end;
      accept     = load_valid && load_ready;
      busy       = (state_q != IDLE);
      sout_valid = busy && !pause;
      load_word  = inv ? ~load_data : load_data;
      done       = done_q;

      case (state_q)
         SHIFT:   sout = shreg_q[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
         PAR:     sout = par_q;
`endif
         default: sout = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      done_d  = frame_end;
`ifdef PISO_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         state_d = SHIFT;
         shreg_d = load_word;
         cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
         par_d   = ^load_word;
`endif
      end else if (frame_end) begin
         state_d = IDLE;
         shreg_d = '0;
         cnt_d   = '0;
      end else if ((state_q == SHIFT) && !pause) begin
         shreg_d = shreg_q << 1;
         cnt_d   = cnt_q + CW'(1);
`ifdef PISO_TX_PARITY_EN
         if (last_bit) state_d = PAR;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized and directed bench for piso_tx against a bit-queue model.
module tb_piso_tx;
   localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk, rst_n, load_valid, load_ready, inv, pause;
   logic [W-1:0] load_data;
   logic         sout, sout_valid, busy, done;

   int checks = 0;
   int errors = 0;

   bit        bq[$];
   bit        done_m;
   bit        acc_m;
   logic [4:0] obs_v, exp_v;
   logic [15:0] rx;
   int        nvalid;

   piso_tx #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .inv(inv), .pause(pause), .sout(sout),
      .sout_valid(sout_valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] frame_val(input logic [W-1:0] w);
`ifdef PISO_TX_PARITY_EN
      return {11'b0, w, ^w};
`else
      return {12'b0, w};
`endif
   endfunction

   task automatic push_frame(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) bq.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
      bq.push_back(^w);
`endif
   endtask

   // One clock: drive inputs, sample outputs, advance the model across the edge.
   task automatic cycle(input logic lv, input logic [W-1:0] d, input logic iv, input logic p);
      bit busy_m;
      load_valid = lv; load_data = d; inv = iv; pause = p;
      busy_m = (bq.size() > 0);
      exp_v = {busy_m ? logic'(bq[0]) : 1'b0, busy_m && !p,
               !busy_m || (bq.size() == 1 && !p), busy_m, logic'(done_m)};
      #1;
      obs_v = {sout, sout_valid, load_ready, busy, done};
      if (sout_valid === 1'b1) begin
         rx = {rx[14:0], sout};
         nvalid++;
      end
      acc_m  = lv && exp_v[2];
      done_m = 1'b0;
      if (busy_m && !p) begin
         void'(bq.pop_front());
         if (bq.size() == 0) done_m = 1'b1;
      end
      if (acc_m) push_frame(iv ? ~d : d);
      @(negedge clk);
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({sout, sout_valid, load_ready, busy, done} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_hold got %b exp 00100", {sout, sout_valid, load_ready, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 4'hF, 1'b0, 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_idle cyc %0d got %b exp %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_single(input logic [W-1:0] w, input logic iv);
      bit seen = 0;
      rx = '0; nvalid = 0;
      cycle(1'b1, w, iv, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
         errors++;
         $display("FAIL single_load w=%b inv=%b got %b exp %b", w, iv, obs_v, exp_v);
      end
      for (int i = 0; i < 12 && !seen; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL single w=%b inv=%b cyc %0d got %b exp %b", w, iv, i, obs_v, exp_v);
         end
         if (obs_v[0] === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || rx !== frame_val(iv ? ~w : w) || nvalid != FL) begin
         errors++;
         $display("FAIL single_rx w=%b inv=%b done=%0d rx=%h exp %h bits=%0d exp %0d",
                  w, iv, seen, rx, frame_val(iv ? ~w : w), nvalid, FL);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] words[2];
      int idx = 0, ndone = 0, cyc = 0, first = -1, last = -1;
      words[0] = 4'b1100; words[1] = 4'b0011;
      rx = '0; nvalid = 0;
      while (ndone < 2 && cyc < 30) begin
         cycle(idx < 2, words[idx < 2 ? idx : 1], 1'b0, 1'b0);
         if (acc_m) idx++;
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL b2b cyc %0d got %b exp %b", cyc, obs_v, exp_v);
         end
         if (obs_v[3] === 1'b1) begin
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (obs_v[0] === 1'b1) ndone++;
         cyc++;
      end
      load_valid = 1'b0;
      checks++;
      if (ndone != 2 || nvalid != 2 * FL || (last - first + 1) != 2 * FL ||
          rx !== ((frame_val(words[0]) << FL) | frame_val(words[1]))) begin
         errors++;
         $display("FAIL b2b_stream dones=%0d bits=%0d span=%0d rx=%h exp %h",
                  ndone, nvalid, last - first + 1, rx,
                  (frame_val(words[0]) << FL) | frame_val(words[1]));
      end
   endtask

   task automatic test_pause;
      int pcnt = 0, held = 0;
      bit seen = 0;
      rx = '0; nvalid = 0;
      cycle(1'b1, 4'b1001, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !seen; i++) begin
         if (nvalid == 2 && pcnt < 3) begin
            pcnt++;
            cycle(1'b0, '0, 1'b0, 1'b1);
            if (obs_v[4:3] === 2'b00 && obs_v[1] === 1'b1) held++;
         end else begin
            cycle(1'b0, '0, 1'b0, 1'b0);
         end
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL pause cyc %0d got %b exp %b", i, obs_v, exp_v);
         end
         if (obs_v[0] === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || held != 3 || nvalid != FL || rx !== frame_val(4'b1001)) begin
         errors++;
         $display("FAIL pause_frame done=%0d held=%0d bits=%0d rx=%h exp %h",
                  seen, held, nvalid, rx, frame_val(4'b1001));
      end
   endtask

   task automatic test_reset_mid;
      nvalid = 0;
      cycle(1'b1, 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 10 && nvalid < 2; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      bq.delete();
      done_m = 1'b0;
      #1;
      checks++;
      if ({sout, sout_valid, load_ready, busy, done} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_mid got %b exp 00100", {sout, sout_valid, load_ready, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_after cyc %0d got %b exp %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL random cyc %0d got %b exp %b", i, obs_v, exp_v);
         end
      end
      for (int i = 0; i < 2 * FL + 2; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_data = '0; inv = 1'b0; pause = 1'b0;
      rx = '0; nvalid = 0; done_m = 1'b0;
      @(negedge clk);
      test_reset();
      test_single(4'b1011, 1'b0);
      test_single(4'b1011, 1'b1);
      test_single(4'b0111, 1'b0);
      test_back_to_back();
      test_pause();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial-shift interface used by the universal shift register blocks.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first on sout, with a per-bit strobe.
- A left-shifting receiver that samples sout on each sout_valid cycle holds the original word after WIDTH shifts.

Parameters:
WIDTH, 4, data word width in bits (≥2)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  transmitter can accept a word this cycle
load_data  input  WIDTH  word to transmit
inv  input  1  sampled with load_data; 1 = transmit bitwise complement
pause  input  1  1 = freeze shifting (hold state, counter, shift register)
sout  output  1  serial data bit, MSB first
sout_valid  output  1  sout carries a valid bit this cycle
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after final bit of frame

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate): state=IDLE, shift reg=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, SHIFT (plus PAR when PARITY_EN).
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - Accept at the edge where load_valid&&load_ready. Capture shreg = inv ? ~load_data : load_data, cnt=0, go to SHIFT.
- SHIFT:
  - sout=shreg[WIDTH-1] and sout_valid=!pause, both combinational from registers.
  - Each edge with pause=0: shreg <= shreg<<1 (LSB fill 0), cnt++.
  - pause=1: all registers hold, sout_valid=0, sout still shows the current bit.
- Last bit (cnt==WIDTH-1, pause=0):
  - Without parity: load_ready=1 this cycle.
  - If a word is accepted at that edge, it is captured and the machine stays in SHIFT with cnt=0 (back-to-back frames, no gap).
  - Otherwise the machine returns to IDLE.
- load_ready=0 in every other SHIFT/PAR cycle. load_valid without ready is ignored; the word is not captured.
- done: registered. It is 1 for exactly one cycle following the edge that consumes the frame's final serial bit, including when a new frame starts back-to-back.
- busy=1 whenever state!=IDLE.
- Latency: first bit is on sout the cycle after acceptance. A frame occupies WIDTH non-paused cycles (WIDTH+1 with parity).
- Counter width: clog2(WIDTH+1). It must not wrap within a frame.

Optional Feature:
- Macro: PISO_TX_PARITY_EN
- Defined:
  - At acceptance, compute an even-parity bit over the captured (post-inv) word.
  - After the last data bit, enter PAR for one non-paused cycle: sout=parity, sout_valid=!pause.
  - The back-to-back load_ready window moves to the PAR cycle.
  - done follows the PAR bit.
- Undefined: no PAR state; frame length is WIDTH bits.

Test Plan:
- Reset then idle: load_valid=0 → load_ready=1, sout_valid=0, busy=0, done never asserted.
- Load 4'b1011, inv=0 → sout sequence 1,0,1,1 with sout_valid=1 for 4 consecutive cycles. done=1 in the next cycle. A receiver model shifting left on sout_valid holds 4'b1011.
- Load 4'b1011, inv=1 → sout 0,1,0,0. Receiver model holds 4'b0100.
- Back-to-back: 4'b1100 then 4'b0011 with load_valid held high → 8 contiguous valid bits 1,1,0,0,0,0,1,1. done pulses once between the two frames and once after the second. No idle gap.
- Pause: load 4'b1001, pause=1 for 3 cycles after the 2nd bit → sout_valid drops for 3 cycles, sout holds 0, then resumes 0,1. Total valid bits = 4.
- Reset mid-frame: assert rst_n=0 after the 2nd bit of 4'b1111 → sout=0, sout_valid=0, busy=0, load_ready=1 immediately. No done pulse.
- With PISO_TX_PARITY_EN: 4'b0111 → 0,1,1,1 then parity bit 1, 5 valid bits total. done comes after the parity bit.
